// File: rtl/cover_toggle_counter_bank_pkg.sv
// Shared types for the toggle-cover counter bank: drain FSM states and the record layout.
package cover_pkg;

   localparam int unsigned COVER_IDX_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EMIT,
      DONE
   } cover_dump_state_e;

   typedef struct packed {
      logic [COVER_IDX_W-1:0] index;
      logic [31:0]            count;
   } cover_rec_t;

endpackage

// File: rtl/cover_toggle_counter_bank_sat_counter.sv
// One cover bin: saturating hit counter with clear and load-one (clear-on-read with a same-cycle hit).
module cover_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic             load1,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         q <= '0;
      end else if (load1) begin
         q <= CNT_W'(1);
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cover_toggle_counter_bank.sv
// Per-bin toggle cover counters drained as {global index, count} records over a valid/ready stream.
module cover_toggle_counter_bank
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH         = 9,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned COVER_INDEX   = 0,
  parameter int unsigned COVER_TOTAL   = 10906,
  parameter bit          CLEAR_ON_READ = 1'b1,
  parameter bit          SKIP_ZERO     = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       valid,
  input  logic                   clear,
  input  logic                   dump_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CNT_W-1:0]       out_count,
  output logic                   busy,
  output logic                   dump_done
);

  localparam int unsigned PTR_W = $clog2(WIDTH + 1);

  if ((WIDTH < 1) || (WIDTH > 1024)) begin : g_bad_width
    $error("cover_toggle_counter_bank: WIDTH must be 1..1024");
  end
  if ((COVER_INDEX + WIDTH) > COVER_TOTAL) begin : g_bad_index
    $error("cover_toggle_counter_bank: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  cover_dump_state_e state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              latch;
  logic [CNT_W-1:0]  bin_q [WIDTH];
  logic [CNT_W-1:0]  cur_cnt;
  logic              handshake;
  logic              clear_all;

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign dump_done = (state_q == DONE);
  assign handshake = out_valid && out_ready;
  assign clear_all = clear && (state_q == IDLE);

  // A handshake on the current bin restarts it from the hit arriving in that same cycle.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bin
    logic rd;
    assign rd = handshake && (ptr_q == PTR_W'(i)) && CLEAR_ON_READ;

    cover_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock(clock),
      .reset(reset),
      .inc  (valid[i]),
      .clr  (clear_all || (rd && !valid[i])),
      .load1(rd && valid[i]),
      .q    (bin_q[i])
    );
  end

  always_comb begin
    cur_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        cur_cnt = bin_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        if (ptr_q == PTR_W'(WIDTH)) begin
          state_d = DONE;
        end else if (SKIP_ZERO && (cur_cnt == '0)) begin
          ptr_d = ptr_q + PTR_W'(1);
        end else begin
          state_d = EMIT;
          latch   = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = SCAN;
          ptr_d   = ptr_q + PTR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      out_index <= '0;
      out_count <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (latch) begin
        out_index <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(ptr_q);
        out_count <= cur_cnt;
      end
    end
  end

endmodule
